// File: rtl/err_log_pkg.sv
// -----------------------------------------------------------------------------
// err_log_pkg
// Shared definitions for the burst logger: FSM state encoding, default
// widths/depth and the record-width and overflow-counter-width constants.
// Imported by err_burst_logger.
// -----------------------------------------------------------------------------
package err_log_pkg;

   // Default timestamp width, burst-length width and FIFO depth (records)
   localparam int TS_W_DFLT  = 32;
   localparam int LEN_W_DFLT = 16;
   localparam int DEPTH_DFLT = 16;

   // One FIFO record is {start_ts, len}
   localparam int REC_W = TS_W_DFLT + LEN_W_DFLT;

   // Width of the dropped-record counter
   localparam int OVF_CNT_W = 16;

   // Burst detector states
   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } burst_state_t;

   // Record width for a given pair of field widths
   function automatic int rec_width(input int ts_w, input int len_w);
      return ts_w + len_w;
   endfunction

endpackage

// File: rtl/err_log_fifo.sv
// -----------------------------------------------------------------------------
// err_log_fifo
// Synchronous first-word-fall-through FIFO for burst records.
//
// Parameters:
//   REC_W  record width in bits
//   DEPTH  depth in records (power of 2, >= 2)
//
// Ports:
//   CLK        clock
//   RST_PER    asynchronous active-high reset (empties the FIFO)
//   clr        synchronous clear (empties the FIFO)
//   push       write request; accepted when not full, or when full and a pop
//              happens on the same edge
//   push_data  record to write
//   pop        read request; ignored while empty
//   head       oldest record, valid whenever empty=0 (zero when empty)
//   level      number of records stored
//   full       level == DEPTH
//   empty      level == 0
// -----------------------------------------------------------------------------
module err_log_fifo #(
   parameter int REC_W = 48,
   parameter int DEPTH = 16
) (
   input  logic                     CLK,
   input  logic                     RST_PER,
   input  logic                     clr,
   input  logic                     push,
   input  logic [REC_W-1:0]         push_data,
   input  logic                     pop,
   output logic [REC_W-1:0]         head,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [REC_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      level_reg;
   logic             pop_ok;
   logic             push_ok;

   assign empty = (level_reg == '0);
   assign full  = (level_reg == (AW+1)'(DEPTH));

   // A pop frees the slot on the same edge, so a full FIFO may still take a
   // push when it is being read; the written slot is the one just consumed.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_ff @(posedge CLK or posedge RST_PER) begin
      if (RST_PER) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else if (clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   level_reg <= level_reg + (AW+1)'(1);
            2'b01:   level_reg <= level_reg - (AW+1)'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

   // Storage carries no reset; stale contents are never visible because the
   // head is masked while empty.
   always_ff @(posedge CLK) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   assign head  = empty ? '0 : mem[rd_ptr_reg];
   assign level = level_reg;

endmodule

// File: rtl/err_burst_logger.sv
// -----------------------------------------------------------------------------
// err_burst_logger
// Groups consecutive mismatch cycles from the error-count stage into bursts
// and queues one {start_ts, len} record per burst for the peripheral.
//
// Optional feature macro: ERR_LOG_OVF_CNT_EN
//   defined   -> OVF_CNT port and 16-bit saturating dropped-record counter
//   undefined -> no OVF_CNT port; OVF sticky flag still present
//
// Parameters: TS_W (timestamp bits), LEN_W (length bits), DEPTH (records)
//
// Ports:
//   CLK       clock (same as error-count stage)
//   RST_PER   asynchronous active-high reset
//   EN        logging enable: timestamp runs and bursts are detected only
//             while high
//   CLR       synchronous clear of timestamp, FIFO, FSM and overflow state
//   COMP_IN   per-cycle mismatch flag
//   RD_READY  peripheral accepts the head record
//   RD_VALID  FIFO not empty
//   RD_DATA   head record {start_ts, len}
//   FIFO_LVL  records currently stored
//   BUSY      burst in progress
//   OVF       sticky: a record was dropped since reset/CLR
//   OVF_CNT   dropped-record count (macro-dependent)
// -----------------------------------------------------------------------------
module err_burst_logger
   import err_log_pkg::*;
#(
   parameter int TS_W  = TS_W_DFLT,
   parameter int LEN_W = LEN_W_DFLT,
   parameter int DEPTH = DEPTH_DFLT
) (
   input  logic                        CLK,
   input  logic                        RST_PER,
   input  logic                        EN,
   input  logic                        CLR,
   input  logic                        COMP_IN,
   input  logic                        RD_READY,
   output logic                        RD_VALID,
   output logic [TS_W+LEN_W-1:0]       RD_DATA,
   output logic [$clog2(DEPTH):0]      FIFO_LVL,
   output logic                        BUSY,
   output logic                        OVF
`ifdef ERR_LOG_OVF_CNT_EN
   ,
   output logic [OVF_CNT_W-1:0]        OVF_CNT
`endif
);

   localparam int RW = TS_W + LEN_W;

   burst_state_t     state_reg;
   burst_state_t     state_next;
   logic [TS_W-1:0]  ts_reg;
   logic [TS_W-1:0]  start_reg;
   logic [TS_W-1:0]  start_next;
   logic [LEN_W-1:0] len_reg;
   logic [LEN_W-1:0] len_next;
   logic             close_burst;
   logic             push;
   logic             pop_eff;
   logic             drop;
   logic             ovf_reg;
   logic             fifo_full;
   logic             fifo_empty;
   logic [RW-1:0]    fifo_head;

   // ---------------------------------------------------------------------
   // Free-running timestamp, gated by EN
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST_PER) begin
      if (RST_PER) begin
         ts_reg <= '0;
      end else if (CLR) begin
         ts_reg <= '0;
      end else if (EN) begin
         ts_reg <= ts_reg + TS_W'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Burst FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST_PER) begin
      if (RST_PER) begin
         state_reg <= IDLE;
         start_reg <= '0;
         len_reg   <= '0;
      end else if (CLR) begin
         state_reg <= IDLE;
         start_reg <= '0;
         len_reg   <= '0;
      end else begin
         state_reg <= state_next;
         start_reg <= start_next;
         len_reg   <= len_next;
      end
   end

   // ---------------------------------------------------------------------
   // Burst FSM: next state. The closing cycle always returns to IDLE, so a
   // mismatch on that same edge cannot open a new burst.
   // ---------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      start_next  = start_reg;
      len_next    = len_reg;
      close_burst = 1'b0;
      case (state_reg)
         IDLE: begin
            if (EN && COMP_IN) begin
               start_next = ts_reg;
               len_next   = LEN_W'(1);
               state_next = BURST;
            end
         end
         BURST: begin
            if (EN && COMP_IN) begin
               // Length saturates; the burst itself keeps running
               if (len_reg != '1) begin
                  len_next = len_reg + LEN_W'(1);
               end
            end else begin
               close_burst = 1'b1;
               state_next  = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // A burst open when CLR arrives is discarded rather than recorded
   assign push    = close_burst & ~CLR;
   assign pop_eff = RD_READY & ~fifo_empty;
   assign drop    = push & fifo_full & ~pop_eff;

   // ---------------------------------------------------------------------
   // Record FIFO
   // ---------------------------------------------------------------------
   err_log_fifo #(
      .REC_W (RW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .RST_PER   (RST_PER),
      .clr       (CLR),
      .push      (push),
      .push_data ({start_reg, len_reg}),
      .pop       (RD_READY),
      .head      (fifo_head),
      .level     (FIFO_LVL),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // ---------------------------------------------------------------------
   // Overflow tracking
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST_PER) begin
      if (RST_PER) begin
         ovf_reg <= 1'b0;
      end else if (CLR) begin
         ovf_reg <= 1'b0;
      end else if (drop) begin
         ovf_reg <= 1'b1;
      end
   end

`ifdef ERR_LOG_OVF_CNT_EN
   logic [OVF_CNT_W-1:0] ovf_cnt_reg;

   always_ff @(posedge CLK or posedge RST_PER) begin
      if (RST_PER) begin
         ovf_cnt_reg <= '0;
      end else if (CLR) begin
         ovf_cnt_reg <= '0;
      end else if (drop && (ovf_cnt_reg != '1)) begin
         ovf_cnt_reg <= ovf_cnt_reg + OVF_CNT_W'(1);
      end
   end

   assign OVF_CNT = ovf_cnt_reg;
`endif

   assign RD_VALID = ~fifo_empty;
   assign RD_DATA  = fifo_head;
   assign BUSY     = (state_reg == BURST);
   assign OVF      = ovf_reg;

endmodule

// File: tb/tb_err_burst_logger.sv
// -----------------------------------------------------------------------------
// tb_err_burst_logger
// Directed bench for err_burst_logger (TS_W=32, LEN_W=4, DEPTH=4). Expected
// records go into a scoreboard queue as bursts are driven and are compared
// against RD_DATA whenever the bench pops a record.
// -----------------------------------------------------------------------------
module tb_err_burst_logger;

   localparam int TS_W  = 32;
   localparam int LEN_W = 4;
   localparam int DEPTH = 4;
   localparam int RW    = TS_W + LEN_W;

   logic                   CLK = 1'b0;
   logic                   RST_PER;
   logic                   EN;
   logic                   CLR;
   logic                   COMP_IN;
   logic                   RD_READY;
   logic                   RD_VALID;
   logic [RW-1:0]          RD_DATA;
   logic [$clog2(DEPTH):0] FIFO_LVL;
   logic                   BUSY;
   logic                   OVF;
`ifdef ERR_LOG_OVF_CNT_EN
   logic [15:0]            OVF_CNT;
`endif

   int            pass_cnt  = 0;
   int            fail_cnt  = 0;
   int            total_cnt = 0;
   logic [31:0]   tsm;
   logic [RW-1:0] sb [$];
   logic [31:0]   st [6];
   logic [31:0]   s;
   int            busy_n;

   err_burst_logger #(
      .TS_W  (TS_W),
      .LEN_W (LEN_W),
      .DEPTH (DEPTH)
   ) dut (
      .CLK      (CLK),
      .RST_PER  (RST_PER),
      .EN       (EN),
      .CLR      (CLR),
      .COMP_IN  (COMP_IN),
      .RD_READY (RD_READY),
      .RD_VALID (RD_VALID),
      .RD_DATA  (RD_DATA),
      .FIFO_LVL (FIFO_LVL),
      .BUSY     (BUSY),
      .OVF      (OVF)
`ifdef ERR_LOG_OVF_CNT_EN
      ,
      .OVF_CNT  (OVF_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [RW-1:0] rec(input logic [31:0] st_ts, input int len);
      return {st_ts, LEN_W'(len)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: drive inputs, compare the head if it will be popped
   // on the coming edge, advance to the next negedge.
   task automatic step(input logic en, input logic comp, input logic rdy, input logic clr);
      logic [RW-1:0] e;
      EN       = en;
      COMP_IN  = comp;
      RD_READY = rdy;
      CLR      = clr;
      if (rdy && RD_VALID && !clr) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_record", 64'(RD_DATA), 64'(0));
         end else begin
            e = sb.pop_front();
            chk("sb_record", 64'(RD_DATA), 64'(e));
         end
      end
      @(posedge CLK);
      if (clr) tsm = '0;
      else if (en) tsm = tsm + 32'd1;
      @(negedge CLK);
   endtask

   // One-cycle burst followed by its closing cycle and one idle cycle
   task automatic one_burst(output logic [31:0] st_ts);
      st_ts = tsm;
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      RST_PER  = 1'b1;
      EN       = 1'b0;
      CLR      = 1'b0;
      COMP_IN  = 1'b0;
      RD_READY = 1'b0;
      tsm      = '0;
      #12;
      chk("rst_valid", 64'(RD_VALID), 64'(0));
      chk("rst_data",  64'(RD_DATA),  64'(0));
      chk("rst_lvl",   64'(FIFO_LVL), 64'(0));
      chk("rst_busy",  64'(BUSY),     64'(0));
      chk("rst_ovf",   64'(OVF),      64'(0));
`ifdef ERR_LOG_OVF_CNT_EN
      chk("rst_ovf_cnt", 64'(OVF_CNT), 64'(0));
`endif
      @(negedge CLK);
      RST_PER = 1'b0;

      // Single burst at edges 5..7
      for (int k = 0; k < 9; k++) begin
         step(1'b1, (k >= 5 && k <= 7), 1'b0, 1'b0);
         if (k == 4) chk("t1_busy_pre", 64'(BUSY), 64'(0));
         if (k == 7) chk("t1_busy", 64'(BUSY), 64'(1));
      end
      sb.push_back(rec(32'd5, 3));
      chk("t1_valid", 64'(RD_VALID), 64'(1));
      chk("t1_lvl",   64'(FIFO_LVL), 64'(1));
      chk("t1_data",  64'(RD_DATA),  64'(rec(32'd5, 3)));
      chk("t1_busy_fall", 64'(BUSY), 64'(0));
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("t1_lvl_pop", 64'(FIFO_LVL), 64'(0));
      chk("t1_empty",   64'(RD_VALID), 64'(0));

      // Length saturation: 20 mismatch cycles, LEN_W=4
      s = tsm;
      busy_n = 0;
      for (int k = 0; k < 20; k++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0);
         if (BUSY) busy_n++;
      end
      chk("t2_busy_cycles", 64'(busy_n), 64'(20));
      step(1'b1, 1'b0, 1'b0, 1'b0);
      sb.push_back(rec(s, 15));
      chk("t2_data", 64'(RD_DATA), 64'(rec(s, 15)));
      chk("t2_busy_fall", 64'(BUSY), 64'(0));
      step(1'b1, 1'b0, 1'b1, 1'b0);

      // Overflow: 6 bursts into a 4-deep FIFO, no reads
      for (int i = 0; i < 6; i++) begin
         one_burst(st[i]);
         if (i < 4) sb.push_back(rec(st[i], 1));
         if (i == 3) chk("t3_ovf_at_full", 64'(OVF), 64'(0));
      end
      chk("t3_lvl",  64'(FIFO_LVL), 64'(4));
      chk("t3_ovf",  64'(OVF),      64'(1));
      chk("t3_head", 64'(RD_DATA),  64'(rec(st[0], 1)));
`ifdef ERR_LOG_OVF_CNT_EN
      chk("t3_ovf_cnt", 64'(OVF_CNT), 64'(2));
`endif

      // CLR, then full FIFO with push and pop on the same edge
      step(1'b1, 1'b0, 1'b0, 1'b1);
      sb.delete();
      chk("t4_clr_lvl",   64'(FIFO_LVL), 64'(0));
      chk("t4_clr_valid", 64'(RD_VALID), 64'(0));
      chk("t4_clr_ovf",   64'(OVF),      64'(0));
      chk("t4_clr_data",  64'(RD_DATA),  64'(0));
`ifdef ERR_LOG_OVF_CNT_EN
      chk("t4_clr_ovf_cnt", 64'(OVF_CNT), 64'(0));
`endif
      for (int i = 0; i < 4; i++) begin
         one_burst(st[i]);
         sb.push_back(rec(st[i], 1));
      end
      chk("t4_full", 64'(FIFO_LVL), 64'(4));
      s = tsm;
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      sb.push_back(rec(s, 1));
      chk("t4_lvl_kept", 64'(FIFO_LVL), 64'(4));
      chk("t4_no_ovf",   64'(OVF),      64'(0));
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("t4_drained", 64'(FIFO_LVL), 64'(0));
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("t4_pop_empty_lvl",   64'(FIFO_LVL), 64'(0));
      chk("t4_pop_empty_valid", 64'(RD_VALID), 64'(0));

      // EN drop during a burst
      s = tsm;
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      sb.push_back(rec(s, 3));
      chk("t5_busy_fall", 64'(BUSY),    64'(0));
      chk("t5_data",      64'(RD_DATA), 64'(rec(s, 3)));
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t5_no_burst", 64'(BUSY),     64'(0));
      chk("t5_lvl",      64'(FIFO_LVL), 64'(1));
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t5_restart", 64'(BUSY), 64'(1));
      step(1'b1, 1'b0, 1'b0, 1'b0);
      // Timestamp frozen while EN=0: new start is three past the last one
      sb.push_back(rec(s + 32'd3, 1));
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("t5_drained", 64'(FIFO_LVL), 64'(0));

      // CLR mid-burst with two records queued
      for (int i = 0; i < 2; i++) begin
         one_burst(st[i]);
         sb.push_back(rec(st[i], 1));
      end
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t6_busy", 64'(BUSY),     64'(1));
      chk("t6_lvl",  64'(FIFO_LVL), 64'(2));
      step(1'b1, 1'b1, 1'b0, 1'b1);
      sb.delete();
      chk("t6_clr_lvl",   64'(FIFO_LVL), 64'(0));
      chk("t6_clr_busy",  64'(BUSY),     64'(0));
      chk("t6_clr_valid", 64'(RD_VALID), 64'(0));
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      sb.push_back(rec(32'd0, 1));
      chk("t6_lvl_after", 64'(FIFO_LVL), 64'(1));
      step(1'b1, 1'b0, 1'b1, 1'b0);

      // RST_PER mid-burst with two records queued
      for (int i = 0; i < 2; i++) begin
         one_burst(st[i]);
         sb.push_back(rec(st[i], 1));
      end
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t7_busy", 64'(BUSY), 64'(1));
      #2;
      RST_PER = 1'b1;
      #1;
      chk("t7_rst_lvl",   64'(FIFO_LVL), 64'(0));
      chk("t7_rst_busy",  64'(BUSY),     64'(0));
      chk("t7_rst_valid", 64'(RD_VALID), 64'(0));
      chk("t7_rst_data",  64'(RD_DATA),  64'(0));
      sb.delete();
      @(negedge CLK);
      RST_PER = 1'b0;
      tsm     = '0;
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      sb.push_back(rec(32'd0, 1));
      chk("t7_lvl_after", 64'(FIFO_LVL), 64'(1));
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("t7_drained", 64'(FIFO_LVL), 64'(0));
      chk("sb_all_read", 64'(sb.size()), 64'(0));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/err_burst_logger.md
# err_burst_logger

Downstream consumer of the per-cycle mismatch flag produced by the DICE error-count stage (`comp_out`, 1 = sampled DUT data differs from the RPG pattern). It groups consecutive mismatch cycles into bursts. Each burst becomes a record {start timestamp, length}, stored in a small FIFO. The peripheral drains the FIFO over a valid/ready interface, so upset events can be told apart from a single total count.

## Interface
- TS_W, 32: timestamp width (bits)
- LEN_W, 16: burst-length width (bits)
- DEPTH, 16: FIFO depth in records; power of 2, ≥2
- CLK  in  1  clock; same clock as the error-count stage
- RST_PER  in  1  reset; asynchronous, active-high
- EN  in  1  logging enable; timestamp runs and bursts are detected only while high
- CLR  in  1  synchronous clear of timestamp, FIFO, FSM and overflow state
- COMP_IN  in  1  per-cycle mismatch flag from the error-count stage
- RD_READY  in  1  peripheral accepts the head record
- RD_VALID  out  1  FIFO not empty
- RD_DATA  out  TS_W+LEN_W  head record: {start_ts[TS_W-1:0], len[LEN_W-1:0]}
- FIFO_LVL  out  $clog2(DEPTH)+1  records currently stored
- BUSY  out  1  burst in progress (FSM in BURST)
- OVF  out  1  sticky: at least one record dropped since reset/CLR
- OVF_CNT  out  16  dropped-record count; present only with ERR_LOG_OVF_CNT_EN

## Operation
- Timestamp counter TS increments by 1 on every CLK edge where EN=1. It wraps modulo 2^TS_W and holds while EN=0.
- FSM states: IDLE, BURST.
  - IDLE, EN=1 and COMP_IN=1: capture start_ts=TS (pre-increment value), len=1, go to BURST.
  - BURST, EN=1 and COMP_IN=1: len+1, saturating at 2^LEN_W-1. The burst continues after saturation.
  - BURST, COMP_IN=0 or EN=0: push {start_ts,len}, go to IDLE. A new burst cannot start in this closing cycle. The earliest start is the next mismatch cycle.
- Push rule: the record is accepted if the FIFO is not full, or if a pop occurs in the same cycle (full FIFO with a simultaneous pop accepts the push). Otherwise the record is dropped, OVF is set, and OVF_CNT increments (saturating at 0xFFFF, when the macro is defined).
- Read: first-word-fall-through. RD_DATA is valid whenever RD_VALID=1. A pop happens on an edge where RD_VALID=1 and RD_READY=1. RD_READY while empty is ignored.
- When empty, push and pop in the same cycle cannot occur (RD_VALID=0). When not empty, simultaneous push and pop leaves FIFO_LVL unchanged.
- CLR has priority over all other activity:
  - TS=0, FIFO emptied, FSM to IDLE, OVF=0, OVF_CNT=0.
  - An in-progress burst is discarded without a push.
  - COMP_IN in the CLR cycle is ignored.
- RST_PER mid-operation: all state is cleared asynchronously, exactly as CLR but without waiting for an edge.

## Timing
- Reset values: RD_VALID=0, RD_DATA=0, FIFO_LVL=0, BUSY=0, OVF=0, OVF_CNT=0, TS=0, FSM=IDLE.
- BUSY rises the cycle after the first mismatch edge and falls the cycle after the closing edge.
- Push latency: a record pushed on closing edge N is visible with RD_VALID=1 after edge N (same cycle as BUSY falling).
- Pop: FIFO_LVL and the head record update after the accepting edge. Back-to-back pops at one record per cycle are supported.
- Start_ts semantics: after reset with EN held high, a first mismatch at the k-th edge (k=0 for the first) records start_ts=k.

## Configuration
- ERR_LOG_OVF_CNT_EN defined: the OVF_CNT port and its 16-bit saturating counter are compiled in.
- ERR_LOG_OVF_CNT_EN undefined: the OVF_CNT port and counter are absent. OVF sticky-flag behaviour is unchanged.

## Structure
- Shared package err_log_pkg:
  - FSM state enum (IDLE, BURST).
  - Default TS_W, LEN_W and DEPTH constants.
  - Record-width constant REC_W = TS_W+LEN_W.
  - OVF_CNT width constant (16).
- One sub-module, err_log_fifo: synchronous FWFT FIFO with parameters REC_W and DEPTH.
  - Ports: push, push_data, pop, head, level, full, empty.
  - Implements the full-with-simultaneous-pop acceptance rule.
- The top level holds TS, the FSM, the len/start registers and the overflow logic.

## Test plan
- Single burst: reset, EN=1, COMP_IN=1 at edges 5–7 only, RD_READY=0 → one record {5,3}, RD_VALID=1 after edge 8, FIFO_LVL=1.
- Saturation: LEN_W=4, COMP_IN=1 for 20 cycles → record len=15, BUSY high for 20 cycles.
- Overflow: DEPTH=4, RD_READY=0, 6 one-cycle bursts separated by idle cycles → FIFO_LVL=4, OVF=1, OVF_CNT=2 (macro on), RD_DATA holds the first burst's record.
- Full with simultaneous pop: FIFO full, burst closes on the same edge as a pop → push accepted, FIFO_LVL stays at DEPTH, OVF stays 0.
- EN drop: burst of 3 cycles, then EN=0 while COMP_IN stays 1 → record len=3, TS frozen, no new burst until EN=1.
- Clear/reset mid-burst: CLR (then separately RST_PER) asserted during BURST with 2 records queued → FIFO_LVL=0, BUSY=0, TS=0, no record pushed for the aborted burst.
